// File: rtl/core_ctl_pkg.sv
// rtl/core_ctl_pkg.sv - shared types and constants for the pipeline sequencing controller
package core_ctl_pkg;

  // Flush sequencer states
  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // x0 is hardwired zero and never takes part in dependency tracking
  localparam logic [4:0] REG_X0 = 5'd0;

  localparam int NREG          = 32;
  localparam int CNT_W_DEF     = 2;
  localparam int FLUSH_CYC_DEF = 1;
  localparam int INFL_W        = 6;

  // True for any register that the scoreboard tracks
  function automatic logic reg_live(input logic [4:0] r);
    return r != REG_X0;
  endfunction

endpackage

// File: rtl/pipe_ctl_if.sv
// rtl/pipe_ctl_if.sv - D-stage issue, W-stage retire and flush signalling bundle
interface pipe_ctl_if;
  import core_ctl_pkg::*;

  // D stage
  logic              d_valid;
  logic [4:0]        d_regA;
  logic [4:0]        d_regB;
  logic              d_useA;
  logic              d_useB;
  logic [4:0]        d_regD;
  logic              d_w_en;
  // A stage
  logic              a_ready;
  logic              br_en;
  // W stage
  logic              w_regfile;
  logic [4:0]        sel_regfile;
  // controller results
  logic              issue;
  logic              d_ready;
  logic              flush;
  logic [INFL_W-1:0] inflight;
  logic              sb_err;

  // Pipeline side: presents the instruction and retire information
  modport master (
    output d_valid, d_regA, d_regB, d_useA, d_useB, d_regD, d_w_en,
    output a_ready, br_en, w_regfile, sel_regfile,
    input  issue, d_ready, flush, inflight, sb_err
  );

  // Controller side
  modport slave (
    input  d_valid, d_regA, d_regB, d_useA, d_useB, d_regD, d_w_en,
    input  a_ready, br_en, w_regfile, sel_regfile,
    output issue, d_ready, flush, inflight, sb_err
  );

endinterface

// File: rtl/sb_counter.sv
// rtl/sb_counter.sv - saturating per-register pending-write counter
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic zero,
  output logic full,
  output logic underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count;
  logic             up;
  logic             down;

  assign zero      = (count == '0);
  assign full      = (count == CNT_MAX);
  // A retire against an empty count is a bookkeeping error and is dropped
  assign underflow = dec && zero;
  assign up        = inc && !full;
  assign down      = dec && !zero;

  // Simultaneous issue and retire cancel; the count neither wraps nor goes negative
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (up && !down) begin
      count <= count + 1'b1;
    end else if (down && !up) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctl.sv
// rtl/pipe_ctl.sv - scoreboard issue control and branch flush sequencing for the F/D/A/C/W core
module pipe_ctl #(
  parameter int NREG      = core_ctl_pkg::NREG,
  parameter int CNT_W     = core_ctl_pkg::CNT_W_DEF,
  parameter int FLUSH_CYC = core_ctl_pkg::FLUSH_CYC_DEF
) (
  input  logic      clock,
  input  logic      reset,
  pipe_ctl_if.slave bus
);
  import core_ctl_pkg::*;

  localparam logic [7:0] FLUSH_LOAD = 8'(FLUSH_CYC);

  logic [NREG-1:0]   zero;
  logic [NREG-1:0]   full;
  logic [NREG-1:0]   underflow;
  state_t            state;
  logic [7:0]        fl_cnt;
  logic [INFL_W-1:0] inflight_q;
  logic              sb_err_q;
  logic              hazard;
  logic              issue;
  logic              flush;
  logic              issue_w;
  logic              retire_ok;

  // x0 has no counter: it always reads as empty and can never be full
  assign zero[0]      = 1'b1;
  assign full[0]      = 1'b0;
  assign underflow[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_sb
    sb_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clock     (clock),
      .reset     (reset),
      .inc       (issue_w && (bus.d_regD == 5'(i))),
      .dec       (bus.w_regfile && (bus.sel_regfile == 5'(i))),
      .zero      (zero[i]),
      .full      (full[i]),
      .underflow (underflow[i])
    );
  end

  // Registered counts only: a retire this cycle releases a reader next cycle
  assign hazard = (bus.d_useA && reg_live(bus.d_regA) && !zero[bus.d_regA])
               || (bus.d_useB && reg_live(bus.d_regB) && !zero[bus.d_regB])
               || (bus.d_w_en && reg_live(bus.d_regD) &&  full[bus.d_regD]);

  assign flush     = bus.br_en || (state == FLUSH);
  // Holding issue during flush keeps wrong-path writers out of the scoreboard
  assign issue     = bus.d_valid && bus.a_ready && !hazard && !flush;
  assign issue_w   = issue && bus.d_w_en && reg_live(bus.d_regD);
  assign retire_ok = bus.w_regfile && reg_live(bus.sel_regfile) && !zero[bus.sel_regfile];

  assign bus.issue    = issue;
  assign bus.d_ready  = !bus.d_valid || issue;
  assign bus.flush    = flush;
  assign bus.inflight = inflight_q;
  assign bus.sb_err   = sb_err_q;

  // Flush sequencer: br_en cycle is flushed combinationally, FLUSH covers the tail
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      fl_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.br_en && (FLUSH_LOAD != 8'd0)) begin
            state  <= FLUSH;
            fl_cnt <= FLUSH_LOAD;
          end
        end
        FLUSH: begin
          if (bus.br_en) begin
            if (FLUSH_LOAD == 8'd0) begin
              state <= IDLE;
            end
            fl_cnt <= FLUSH_LOAD;
          end else if (fl_cnt <= 8'd1) begin
            state  <= IDLE;
            fl_cnt <= '0;
          end else begin
            fl_cnt <= fl_cnt - 8'd1;
          end
        end
        default: begin
          state  <= IDLE;
          fl_cnt <= '0;
        end
      endcase
    end
  end

  // Total pending writes: +1 per tracked issue, -1 per accepted retire
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_q + INFL_W'(issue_w) - INFL_W'(retire_ok);
    end
  end

  // Sticky record of any retire that found nothing pending
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sb_err_q <= 1'b0;
    end else if (|underflow) begin
      sb_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctl.sv
// tb/tb_pipe_ctl.sv - self-checking bench for pipe_ctl
module tb_pipe_ctl;

  localparam int FLUSH_CYC = 1;
  localparam int NV        = 30;
  localparam int NRND      = 400;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  pipe_ctl_if bus ();

  pipe_ctl #(
    .NREG      (32),
    .CNT_W     (2),
    .FLUSH_CYC (FLUSH_CYC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       v;
    logic [4:0] ra;
    logic       ua;
    logic [4:0] rb;
    logic       ub;
    logic [4:0] rd;
    logic       we;
    logic       ar;
    logic       br;
    logic       wr;
    logic [4:0] ws;
    logic       iss;
    logic       rdy;
    logic       fl;
    logic [5:0] infl;
    logic       err;
  } vec_t;

  vec_t vt [NV];

  function automatic vec_t mk(input logic v, input int ra, input logic ua, input int rb,
                              input logic ub, input int rd, input logic we, input logic ar,
                              input logic br, input logic wr, input int ws, input logic iss,
                              input logic rdy, input logic fl, input int infl, input logic err);
    vec_t t;
    t.v = v;  t.ra = 5'(ra); t.ua = ua; t.rb = 5'(rb); t.ub = ub;
    t.rd = 5'(rd); t.we = we; t.ar = ar; t.br = br; t.wr = wr; t.ws = 5'(ws);
    t.iss = iss; t.rdy = rdy; t.fl = fl; t.infl = 6'(infl); t.err = err;
    return t;
  endfunction

  task automatic drive(input logic v, input logic [4:0] ra, input logic ua, input logic [4:0] rb,
                       input logic ub, input logic [4:0] rd, input logic we, input logic ar,
                       input logic br, input logic wr, input logic [4:0] ws);
    bus.d_valid = v;  bus.d_regA = ra; bus.d_useA = ua; bus.d_regB = rb; bus.d_useB = ub;
    bus.d_regD = rd;  bus.d_w_en = we; bus.a_ready = ar; bus.br_en = br;
    bus.w_regfile = wr; bus.sel_regfile = ws;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model state: pending counts, totals, and the last flushed cycle index
  int  mc [32];
  int  m_infl;
  bit  m_err;
  int  m_cyc;
  int  m_fend;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    vt[0]  = mk(0,0,0,0,0, 0,0,0,0,0,0, 0,1,0,0,0);
    vt[1]  = mk(1,0,0,0,0, 5,1,1,0,0,0, 1,1,0,0,0);
    vt[2]  = mk(1,5,1,0,0, 0,0,1,0,0,0, 0,0,0,1,0);
    vt[3]  = mk(1,5,1,0,0, 0,0,1,0,1,5, 0,0,0,1,0);
    vt[4]  = mk(1,5,1,0,0, 0,0,1,0,0,0, 1,1,0,0,0);
    vt[5]  = mk(1,0,0,0,0, 7,1,1,0,0,0, 1,1,0,0,0);
    vt[6]  = mk(1,0,0,0,0, 7,1,1,0,0,0, 1,1,0,1,0);
    vt[7]  = mk(1,0,0,0,0, 7,1,1,0,0,0, 1,1,0,2,0);
    vt[8]  = mk(1,0,0,0,0, 7,1,1,0,0,0, 0,0,0,3,0);
    vt[9]  = mk(1,0,0,0,0, 7,1,1,0,1,7, 0,0,0,3,0);
    vt[10] = mk(1,0,0,0,0, 7,1,1,0,0,0, 1,1,0,2,0);
    vt[11] = mk(0,0,0,0,0, 0,0,0,0,1,7, 0,1,0,3,0);
    vt[12] = mk(0,0,0,0,0, 0,0,0,0,1,7, 0,1,0,2,0);
    vt[13] = mk(0,0,0,0,0, 0,0,0,0,1,7, 0,1,0,1,0);
    vt[14] = mk(1,0,0,0,0, 0,0,1,1,0,0, 0,0,1,0,0);
    vt[15] = mk(1,0,0,0,0, 0,0,1,1,0,0, 0,0,1,0,0);
    vt[16] = mk(1,0,0,0,0, 0,0,1,0,0,0, 0,0,1,0,0);
    vt[17] = mk(1,0,0,0,0, 0,0,1,0,0,0, 1,1,0,0,0);
    vt[18] = mk(1,0,0,0,0, 3,1,1,0,0,0, 1,1,0,0,0);
    vt[19] = mk(1,0,0,0,0, 3,1,1,0,1,3, 1,1,0,1,0);
    vt[20] = mk(0,0,0,0,0, 0,0,0,0,0,0, 0,1,0,1,0);
    vt[21] = mk(0,0,0,0,0, 0,0,0,0,1,9, 0,1,0,1,0);
    vt[22] = mk(0,0,0,0,0, 0,0,0,0,0,0, 0,1,0,1,1);
    vt[23] = mk(1,0,1,0,1, 0,1,1,0,0,0, 1,1,0,1,1);
    vt[24] = mk(1,0,1,0,1, 0,1,1,0,1,0, 1,1,0,1,1);
    vt[25] = mk(1,3,1,0,0, 0,0,1,0,0,0, 0,0,0,1,1);
    vt[26] = mk(1,0,0,0,0, 4,1,0,0,0,0, 0,0,0,1,1);
    vt[27] = mk(1,0,0,3,1, 0,0,1,0,0,0, 0,0,0,1,1);
    vt[28] = mk(1,0,0,3,0, 0,0,1,0,0,0, 1,1,0,1,1);
    vt[29] = mk(1,0,0,0,0, 3,1,1,0,0,0, 1,1,0,1,1);

    // Reset state with inputs low
    #12;
    chk("reset issue", 32'(bus.issue), 0);
    chk("reset flush", 32'(bus.flush), 0);
    chk("reset d_ready", 32'(bus.d_ready), 1);
    chk("reset inflight", 32'(bus.inflight), 0);
    chk("reset sb_err", 32'(bus.sb_err), 0);
    @(negedge clock);
    reset = 1'b1;

    // Directed vector table, one cycle per entry
    for (int k = 0; k < NV; k++) begin
      @(negedge clock);
      drive(vt[k].v, vt[k].ra, vt[k].ua, vt[k].rb, vt[k].ub, vt[k].rd, vt[k].we,
            vt[k].ar, vt[k].br, vt[k].wr, vt[k].ws);
      #1;
      chk($sformatf("v%0d issue", k), 32'(bus.issue), 32'(vt[k].iss));
      chk($sformatf("v%0d d_ready", k), 32'(bus.d_ready), 32'(vt[k].rdy));
      chk($sformatf("v%0d flush", k), 32'(bus.flush), 32'(vt[k].fl));
      chk($sformatf("v%0d inflight", k), 32'(bus.inflight), 32'(vt[k].infl));
      chk($sformatf("v%0d sb_err", k), 32'(bus.sb_err), 32'(vt[k].err));
    end

    // Asynchronous reset in the middle of a flush with writes outstanding
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("mid br flush", 32'(bus.flush), 1);
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("mid tail flush", 32'(bus.flush), 1);
    chk("mid inflight", 32'(bus.inflight), 2);
    #2;
    reset = 1'b0;
    #1;
    chk("async flush", 32'(bus.flush), 0);
    chk("async inflight", 32'(bus.inflight), 0);
    chk("async sb_err", 32'(bus.sb_err), 0);
    chk("async d_ready", 32'(bus.d_ready), 1);
    @(negedge clock);
    reset = 1'b1;

    // Randomized traffic against the reference model
    for (int r = 0; r < 32; r++) mc[r] = 0;
    m_infl = 0;
    m_err  = 1'b0;
    m_cyc  = 0;
    m_fend = -1;
    for (int i = 0; i < NRND; i++) begin
      logic       v, ua, ub, we, ar, br, wr;
      logic [4:0] ra, rb, rd, ws;
      bit         haz, efl, eiss;
      int         old;
      @(negedge clock);
      v  = ($urandom_range(3) != 0);
      ar = ($urandom_range(3) != 0);
      br = ($urandom_range(9) == 0);
      ua = $urandom_range(1);
      ub = $urandom_range(1);
      ra = 5'($urandom_range(7));
      rb = 5'($urandom_range(7));
      we = $urandom_range(1);
      rd = ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom_range(7, 1));
      wr = $urandom_range(1);
      ws = 5'($urandom_range(7));
      if (wr && ws != 0 && mc[ws] == 0) begin
        if ($urandom_range(19) != 0 || (we && rd == ws)) wr = 1'b0;
      end
      drive(v, ra, ua, rb, ub, rd, we, ar, br, wr, ws);
      #1;
      haz  = (ua && ra != 0 && mc[ra] != 0) || (ub && rb != 0 && mc[rb] != 0)
          || (we && rd != 0 && mc[rd] == 3);
      efl  = br || (m_cyc <= m_fend);
      eiss = v && ar && !haz && !efl;
      chk($sformatf("rnd%0d issue", i), 32'(bus.issue), 32'(eiss));
      chk($sformatf("rnd%0d d_ready", i), 32'(bus.d_ready), 32'(!v || eiss));
      chk($sformatf("rnd%0d flush", i), 32'(bus.flush), 32'(efl));
      chk($sformatf("rnd%0d inflight", i), 32'(bus.inflight), 32'(m_infl));
      chk($sformatf("rnd%0d sb_err", i), 32'(bus.sb_err), 32'(m_err));
      old = mc[ws];
      if (eiss && we && rd != 0) begin
        mc[rd]++;
        m_infl++;
      end
      if (wr && ws != 0) begin
        if (old == 0) m_err = 1'b1;
        else begin
          mc[ws]--;
          m_infl--;
        end
      end
      if (br) m_fend = m_cyc + FLUSH_CYC;
      m_cyc++;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctl.md
# pipe_ctl

Pipeline sequencing controller for the five-stage F/D/A/C/W core. Tracks in-flight register writes in a per-register scoreboard and decides each cycle whether the instruction held in D issues to A or stalls. Sequences the F/D flush after a taken branch resolves in A. Drives `d_ready` back-pressure into F and the flush strobes into F_top/D_top.

## Interface
Parameters:
- NREG, 32, architectural registers; x0 is never tracked
- CNT_W, 2, width of per-register pending counter (max 3 writes in flight per register)
- FLUSH_CYC, 1, registered flush cycles that follow the `br_en` cycle

Ports:
- clock  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- d_valid  in  1  D holds a decoded instruction
- d_regA, d_regB  in  5  source register indices
- d_useA, d_useB  in  1  instruction reads regA / regB
- d_regD  in  5  destination register
- d_w_en  in  1  instruction writes regD
- a_ready  in  1  A can accept an instruction this cycle
- br_en  in  1  taken branch resolved in A this cycle
- w_regfile  in  1  W writes the register file this cycle
- sel_regfile  in  5  register written by W
- issue  out  1  D→A transfer occurs this cycle
- d_ready  out  1  D can accept from F (= !d_valid | issue)
- flush  out  1  squash F and D contents
- inflight  out  6  total pending writes
- sb_err  out  1  sticky: retire on a register with zero count

## Operation
- hazard = (d_useA & d_regA≠0 & cnt[d_regA]≠0) | (d_useB & d_regB≠0 & cnt[d_regB]≠0) | (d_w_en & d_regD≠0 & cnt[d_regD]=2^CNT_W−1).
- issue = d_valid & a_ready & !hazard & !flush; combinational.
- On issue with d_w_en & d_regD≠0: cnt[d_regD]+1, inflight+1.
- On w_regfile & sel_regfile≠0: cnt[sel_regfile]−1, inflight−1. If that count is 0, nothing is decremented and sb_err sets. sb_err clears only on reset.
- Issue and retire to the same register in one cycle: count unchanged.
- Retire in cycle N releases a dependent in N+1, not N. The hazard check uses registered counts; there is no same-cycle bypass.
- FSM:
  - IDLE → FLUSH on br_en; load counter with FLUSH_CYC.
  - In FLUSH, decrement the counter each cycle; return to IDLE when the counter reaches 0 and br_en is low.
  - br_en during FLUSH reloads the counter.
- flush = br_en | (state==FLUSH). No issue while flush is high, so a wrong-path instruction never reaches the scoreboard.
- Writes by x0 and to x0 are ignored everywhere.

## Timing
- Reset values: all cnt 0, inflight 0, state IDLE, sb_err 0.
  - With inputs low: issue 0, flush 0, d_ready 1.
- Issue decision: 0-cycle (same cycle as inputs). Scoreboard update visible the next cycle.
- Flush length: br_en cycle plus FLUSH_CYC cycles. Default is 2 cycles total.
- Reset mid-flush or mid-hazard: returns to IDLE with an empty scoreboard immediately (async). Upstream stages are reset together with this block.
- Counter saturation: an instruction that would overflow cnt stalls until a retire frees a slot; the count never wraps.

## Structure
- Shared package core_ctl_pkg holds:
  - state enum {IDLE, FLUSH}
  - REG_X0 = 5'd0
  - NREG, and the default CNT_W / FLUSH_CYC
- Sub-module sb_counter: CNT_W-bit up/down counter with inc, dec, and outputs zero, full, underflow. It is instantiated NREG−1 times (x1..x31).
- Top level: hazard compare, issue logic, flush FSM, inflight accumulator, sb_err.

## Test plan
- Reset, then d_valid with d_regD=5, d_w_en, a_ready=1 → issue=1; next cycle cnt[5]=1, inflight=1.
- Issue a write to x5, then a reader with d_regA=5, d_useA → issue=0, d_ready=0 until the cycle after w_regfile, sel_regfile=5; then issue=1.
- Four back-to-back writers to x7 with no retire → first three issue, fourth stalls on full count; a retire of x7 lets it issue the next cycle.
- Assert br_en with d_valid=1 and no hazard → flush high for 2 cycles, issue=0 during both; br_en again in the second cycle → flush extends 2 more cycles.
- Same cycle: issue writer to x3 (cnt 1) and retire x3 → cnt[3] stays 1, inflight unchanged. Retire x9 with cnt 0 → sb_err=1, held until reset.
- Reader with d_regA=0, plus writers to x0 → never stall, inflight unchanged. Assert reset low mid-flush → flush=0, inflight=0 immediately.
